// File: rtl/hsv_core_pkg.sv
// hsv_core shared types.
// Word and flush controller state definitions.
package hsv_core_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FLUSH_IDLE,
        FLUSH_DRAIN,
        FLUSH_REDIRECT
    } flush_state_t;

endpackage

// File: rtl/hsv_core_flush_ctrl.sv
// Front-end flush sequencer.
// Drains all stages with flush_req, then hands one redirect PC to fetch.
module hsv_core_flush_ctrl
    import hsv_core_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int MIN_HOLD   = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_core,
    input  logic                  rst_core,
    input  logic                  flush_i,
    input  word_t                 flush_pc_i,
    output logic [NUM_STAGES-1:0] flush_req_o,
    input  logic [NUM_STAGES-1:0] flush_ack_i,
    output logic                  redirect_valid_o,
    output word_t                 redirect_pc_o,
    input  logic                  redirect_ready_i,
    output logic                  busy_o,
    output logic                  timeout_o
);

    localparam int HOLD_W = $clog2(MIN_HOLD + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [HOLD_W-1:0] HOLD_EXIT = HOLD_W'(MIN_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MIN_HOLD);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

    flush_state_t          state_q;
    word_t                 pc_q;
    logic [NUM_STAGES-1:0] ack_mask_q;
    logic [HOLD_W-1:0]     hold_cnt_q;
    logic [WAIT_W-1:0]     wait_cnt_q;
    logic                  timeout_q;

    logic [NUM_STAGES-1:0] ack_eff;
    logic [NUM_STAGES-1:0] ack_all;
    logic                  drain_done;

    // Acks present in the first drain cycle predate our request.
    always_comb begin
        ack_eff    = (hold_cnt_q != '0) ? flush_ack_i : '0;
        ack_all    = ack_mask_q | ack_eff;
        drain_done = (&ack_all) && (hold_cnt_q >= HOLD_EXIT);
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state_q    <= FLUSH_IDLE;
            pc_q       <= '0;
            ack_mask_q <= '0;
            hold_cnt_q <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (flush_i) begin
                // A younger flush always restarts the drain from scratch.
                state_q    <= FLUSH_DRAIN;
                pc_q       <= flush_pc_i;
                ack_mask_q <= '0;
                hold_cnt_q <= '0;
                wait_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    FLUSH_IDLE: begin
                        state_q <= FLUSH_IDLE;
                    end
                    FLUSH_DRAIN: begin
                        ack_mask_q <= ack_all;
                        if (hold_cnt_q != HOLD_SAT) begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                        if (wait_cnt_q != WAIT_MAX) begin
                            wait_cnt_q <= wait_cnt_q + 1'b1;
                            timeout_q  <= (wait_cnt_q == WAIT_MAX - 1'b1);
                        end
                        if (drain_done) begin
                            state_q <= FLUSH_REDIRECT;
                        end
                    end
                    FLUSH_REDIRECT: begin
                        if (redirect_ready_i) begin
                            state_q <= FLUSH_IDLE;
                        end
                    end
                    default: begin
                        state_q <= FLUSH_IDLE;
                    end
                endcase
            end
        end
    end

    assign flush_req_o      = {NUM_STAGES{state_q == FLUSH_DRAIN}};
    assign redirect_valid_o = (state_q == FLUSH_REDIRECT);
    assign redirect_pc_o    = pc_q;
    assign busy_o           = (state_q != FLUSH_IDLE);
    assign timeout_o        = timeout_q;

endmodule
